// File: rtl/tnn_neuron_seq_ctrl.sv
// Time-multiplexes one shared combinational TNN neuron core over a layer of
// neurons and returns the per-neuron votes plus a thresholded class bit.
module tnn_neuron_seq_ctrl #(
  parameter int NUM_FEAT    = 11,
  parameter int NUM_NEURONS = 6,
  parameter int FEAT_W      = 3,
  parameter int THRESH      = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [NUM_FEAT*FEAT_W-1:0]   s_feat,
  output logic [3:0]                   nrn_sel,
  output logic [FEAT_W-1:0]            nrn_a,
  output logic [FEAT_W-1:0]            nrn_b,
  output logic [FEAT_W-1:0]            nrn_c,
  input  logic                         nrn_out,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [NUM_NEURONS-1:0]       m_votes,
  output logic                         m_class
);

  // state | meaning
  // IDLE  | waiting for a sample, s_ready=1
  // EVAL  | driving neuron k on the shared core, latching its vote
  // DONE  | result held on m_* until the sink takes it
  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  localparam int CNT_W = $clog2(NUM_NEURONS + 1);
  localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;

  state_t                       state_q, state_d;
  logic [3:0]                   k_q, k_d;
  logic [NUM_FEAT*FEAT_W-1:0]   feat_q, feat_d;
  logic [NUM_NEURONS-1:0]       votes_q, votes_d, vote_upd;
  logic                         class_q, class_d;
  logic [CNT_W-1:0]             vote_cnt;
  logic                         class_hit;
  logic [31:0]                  base_idx;
  logic [IDX_W-1:0]             idx_a, idx_b, idx_c;

  // Feature indices wrap modulo NUM_FEAT, which need not be a multiple of 3.
  assign base_idx = 32'(k_q) * 32'd3;
  assign idx_a    = IDX_W'(base_idx % NUM_FEAT);
  assign idx_b    = IDX_W'((base_idx + 32'd1) % NUM_FEAT);
  assign idx_c    = IDX_W'((base_idx + 32'd2) % NUM_FEAT);

  assign nrn_a   = feat_q[FEAT_W*idx_a +: FEAT_W];
  assign nrn_b   = feat_q[FEAT_W*idx_b +: FEAT_W];
  assign nrn_c   = feat_q[FEAT_W*idx_c +: FEAT_W];
  assign nrn_sel = k_q;

  assign s_ready = (state_q == IDLE);
  assign m_valid = (state_q == DONE);
  assign m_votes = votes_q;
  assign m_class = class_q;

  always_comb begin
    vote_upd = votes_q;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (k_q == 4'(i)) vote_upd[i] = nrn_out;
    end
  end

  // Class is taken from the vote vector including the final neuron's bit.
  always_comb begin
    vote_cnt = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      vote_cnt = vote_cnt + CNT_W'(vote_upd[i]);
    end
    class_hit = (int'(vote_cnt) >= THRESH);
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    feat_d  = feat_q;
    votes_d = votes_q;
    class_d = class_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          feat_d  = s_feat;
          votes_d = '0;
          k_d     = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        votes_d = vote_upd;
        if (k_q == 4'(NUM_NEURONS - 1)) begin
          class_d = class_hit;
          state_d = DONE;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      DONE: begin
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      feat_q  <= '0;
      votes_q <= '0;
      class_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      feat_q  <= feat_d;
      votes_q <= votes_d;
      class_q <= class_d;
    end
  end

endmodule

// File: tb/tb_tnn_neuron_seq_ctrl.sv
// Directed bench for tnn_neuron_seq_ctrl with a behavioural neuron-core stub
// (either a[2]|b[2] or a programmed per-neuron vote pattern).
module tb_tnn_neuron_seq_ctrl;

  localparam int NF = 11;
  localparam int NN = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_valid;
  logic            s_ready;
  logic [NF*3-1:0] s_feat;
  logic [3:0]      nrn_sel;
  logic [2:0]      nrn_a, nrn_b, nrn_c;
  logic            nrn_out;
  logic            m_valid;
  logic            m_ready;
  logic [NN-1:0]   m_votes;
  logic            m_class;

  logic            use_pat;
  logic [15:0]     pat;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] rec_a [NN];
  logic [2:0] rec_b [NN];
  logic [2:0] rec_c [NN];
  logic [3:0] rec_sel [NN];

  always #5 clk = ~clk;

  assign nrn_out = use_pat ? pat[nrn_sel] : (nrn_a[2] | nrn_b[2]);

  tnn_neuron_seq_ctrl #(.NUM_FEAT(NF), .NUM_NEURONS(NN), .FEAT_W(3), .THRESH(3)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_feat(s_feat),
    .nrn_sel(nrn_sel), .nrn_a(nrn_a), .nrn_b(nrn_b), .nrn_c(nrn_c), .nrn_out(nrn_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_votes(m_votes), .m_class(m_class)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NF*3-1:0] feat_vec(input logic [2:0] f [NF]);
    logic [NF*3-1:0] v;
    for (int i = 0; i < NF; i++) v[3*i +: 3] = f[i];
    return v;
  endfunction

  // Presents a sample in IDLE; returns at the negedge after the accept edge (k=0).
  task automatic send(input logic [NF*3-1:0] fv);
    s_valid = 1'b1;
    s_feat  = fv;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Records the core inputs for every neuron and checks the result latency.
  task automatic eval_phase(input string tag);
    for (int k = 0; k < NN; k++) begin
      rec_sel[k] = nrn_sel;
      rec_a[k]   = nrn_a;
      rec_b[k]   = nrn_b;
      rec_c[k]   = nrn_c;
      if (k == NN - 1) check_val({tag, "_mvalid_early"}, 32'(m_valid), 32'd0);
      @(negedge clk);
    end
    check_val({tag, "_mvalid_lat"}, 32'(m_valid), 32'd1);
    check_val({tag, "_sready_busy"}, 32'(s_ready), 32'd0);
  endtask

  task automatic consume(input string tag);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check_val({tag, "_idle_sready"}, 32'(s_ready), 32'd1);
    check_val({tag, "_idle_mvalid"}, 32'(m_valid), 32'd0);
  endtask

  task automatic run(input string tag, input logic [NF*3-1:0] fv,
                     input logic [NN-1:0] exp_votes, input logic exp_class);
    send(fv);
    eval_phase(tag);
    check_val({tag, "_votes"}, 32'(m_votes), 32'(exp_votes));
    check_val({tag, "_class"}, 32'(m_class), 32'(exp_class));
    consume(tag);
  endtask

  logic [2:0] f [NF];
  logic [NN-1:0] held_votes;
  logic held_class;
  int mv_seen;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_feat = '0; m_ready = 1'b0;
    use_pat = 1'b0; pat = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_sready", 32'(s_ready), 32'd1);
    check_val("rst_mvalid", 32'(m_valid), 32'd0);
    check_val("rst_votes", 32'(m_votes), 32'd0);
    check_val("rst_class", 32'(m_class), 32'd0);
    check_val("rst_sel", 32'(nrn_sel), 32'd0);
    check_val("rst_abc", {23'd0, nrn_a, nrn_b, nrn_c}, 32'd0);

    // All features 3'b100: every neuron sees a[2]=1.
    for (int i = 0; i < NF; i++) f[i] = 3'b100;
    run("all4", feat_vec(f), 6'b111111, 1'b1);
    for (int k = 0; k < NN; k++) check_val("all4_sel", 32'(rec_sel[k]), 32'(k));

    // Only feature 9 set: reached only by neuron 3 on input a.
    for (int i = 0; i < NF; i++) f[i] = 3'b000;
    f[9] = 3'b111;
    run("route", feat_vec(f), 6'b001000, 1'b0);
    check_val("route_k3_a", 32'(rec_a[3]), 32'd7);
    check_val("route_k3_b", 32'(rec_b[3]), 32'd0);
    check_val("route_k3_c", 32'(rec_c[3]), 32'd0);

    // Wrap: k3 -> 9,10,0 ; k4 -> 1,2,3. Votes k0 (a=5) and k4 (a=6) set.
    for (int i = 0; i < NF; i++) f[i] = 3'b000;
    f[0] = 3'd5; f[1] = 3'd6; f[2] = 3'd7;
    run("wrap", feat_vec(f), 6'b010001, 1'b0);
    check_val("wrap_k0", {23'd0, rec_a[0], rec_b[0], rec_c[0]}, {23'd0, 3'd5, 3'd6, 3'd7});
    check_val("wrap_k3", {23'd0, rec_a[3], rec_b[3], rec_c[3]}, {23'd0, 3'd0, 3'd0, 3'd5});
    check_val("wrap_k4", {23'd0, rec_a[4], rec_b[4], rec_c[4]}, {23'd0, 3'd6, 3'd7, 3'd0});

    // Threshold boundary via programmed core pattern.
    use_pat = 1'b1;
    pat = 16'b000111;
    run("thr3", '0, 6'b000111, 1'b1);
    pat = 16'b000011;
    run("thr2", '0, 6'b000011, 1'b0);
    pat = 16'b101010;
    run("thr3b", '0, 6'b101010, 1'b1);
    use_pat = 1'b0;

    // Backpressure with an ignored s_valid pulse.
    for (int i = 0; i < NF; i++) f[i] = 3'b100;
    send(feat_vec(f));
    eval_phase("bp");
    held_votes = m_votes;
    held_class = m_class;
    check_val("bp_votes", 32'(held_votes), 32'h3f);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin s_valid = 1'b1; s_feat = '0; end
      if (c == 5) s_valid = 1'b0;
      @(negedge clk);
      check_val("bp_mvalid", 32'(m_valid), 32'd1);
      check_val("bp_sready", 32'(s_ready), 32'd0);
      check_val("bp_hold", {25'd0, held_class, m_votes}, {25'd0, m_class, 6'h3f});
    end
    consume("bp");
    check_val("bp_after_votes", 32'(m_votes), 32'h3f);
    for (int i = 0; i < NF; i++) f[i] = 3'b000;
    run("bp_next", feat_vec(f), 6'b000000, 1'b0);

    // Reset while neuron k=2 is on the core.
    for (int i = 0; i < NF; i++) f[i] = 3'b100;
    send(feat_vec(f));
    @(negedge clk);
    @(negedge clk);
    check_val("abort_k2", 32'(nrn_sel), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_sready", 32'(s_ready), 32'd1);
    check_val("abort_votes", 32'(m_votes), 32'd0);
    check_val("abort_sel", 32'(nrn_sel), 32'd0);
    mv_seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_valid) mv_seen++;
      @(negedge clk);
    end
    check_val("abort_no_mvalid", 32'(mv_seen), 32'd0);
    for (int i = 0; i < NF; i++) f[i] = 3'b000;
    f[9] = 3'b111;
    run("abort_next", feat_vec(f), 6'b001000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tnn_neuron_seq_ctrl.md
Name: tnn_neuron_seq_ctrl

Overview:
- Sequencer that time-multiplexes one shared combinational approximate TNN neuron core (three 3-bit inputs a/b/c, 1-bit output, plus a neuron-select) across all neurons of a small classifier layer.
- Accepts one feature vector per transaction and drives the core once per neuron, one neuron per cycle.
- Collects the neuron output bits and produces a thresholded class vote on an output handshake.
- Sits between the feature-stream front end and the result sink; the neuron core is instantiated outside this block.

Parameters:
- NUM_FEAT, 11, number of 3-bit input features per sample.
- NUM_NEURONS, 6, number of neuron evaluations per sample; range 1..16.
- FEAT_W, 3, feature width; fixed at 3 to match the neuron core.
- THRESH, 3, class = 1 when the popcount of the neuron outputs is >= THRESH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  sample valid.
- s_ready  out  1  block can accept a sample.
- s_feat  in  NUM_FEAT*FEAT_W  feature i occupies bits [3i+2:3i].
- nrn_sel  out  4  index of the neuron currently evaluated.
- nrn_a  out  3  core input a.
- nrn_b  out  3  core input b.
- nrn_c  out  3  core input c.
- nrn_out  in  1  core output; combinational from nrn_sel/a/b/c.
- m_valid  out  1  result valid.
- m_ready  in  1  sink accepts result.
- m_votes  out  NUM_NEURONS  bit k = output of neuron k.
- m_class  out  1  thresholded vote.

Behaviour:
- Reset: one clk edge with rst=1 forces:
  - state=IDLE, s_ready=1, m_valid=0, m_votes=0, m_class=0, nrn_sel=0;
  - feature register cleared, so nrn_a/b/c=0.
- Reset mid-operation: any in-flight sample is dropped with no partial output.
- States:
  - IDLE: s_ready=1. On s_valid&s_ready, register s_feat, clear the vote register, set k=0, go to EVAL.
  - EVAL: s_ready=0.
    - nrn_sel=k.
    - nrn_a=feat[(3k) mod NUM_FEAT], nrn_b=feat[(3k+1) mod NUM_FEAT], nrn_c=feat[(3k+2) mod NUM_FEAT].
    - Drive a/b/c combinationally from the registered features and k.
    - Each cycle, latch nrn_out into vote bit k.
    - If k=NUM_NEURONS-1, go to DONE; otherwise k=k+1.
  - DONE: m_valid=1. m_votes and m_class are registered and stable while m_valid=1.
    - m_class = (popcount(m_votes) >= THRESH).
    - On m_ready, go to IDLE next cycle with m_valid=0.
- Latency: sample accepted at edge T, neurons evaluated in cycles T+1..T+NUM_NEURONS, m_valid asserted from T+NUM_NEURONS+1.
- Throughput: one sample per NUM_NEURONS+2 cycles when m_ready is held high.
- No overlap: s_ready=0 from acceptance until the result is consumed.
  - s_valid in EVAL/DONE is ignored.
  - The upstream source must hold its data, per the valid/ready protocol.
- m_ready while m_valid=0 has no effect.
- THRESH=0 gives m_class=1 always. THRESH>NUM_NEURONS gives m_class=0 always.
- Feature index wraps modulo NUM_FEAT. The wrap must be correct for non-multiple-of-3 counts.
- Popcount width: clog2(NUM_NEURONS+1) bits, unsigned compare.

Test Plan:
- Reset and default timing: core stub nrn_out=a[2]|b[2].
  - Assert rst for 2 cycles, then check s_ready=1, m_valid=0, m_votes=0.
  - Send s_feat with all features=3'b100 at T: m_valid rises at T+7, m_votes=6'b111111, m_class=1.
- Feature routing: all features=0 except feature 9=3'b111, same stub.
  - Cycle k=3 must show nrn_a=3'b111, nrn_b=0, nrn_c=0.
  - Result m_votes=6'b001000, m_class=0.
- Wrap-around: feature 0=5, feature 1=6, feature 2=7, others 0.
  - k=3 drives a=feat9, b=feat10, c=feat0=5.
  - k=4 drives a=6, b=7, c=0.
  - Checks indices 0..2 and the mod-11 wrap.
- Threshold boundary: stub returns a programmed pattern.
  - Votes 6'b000111 (popcount 3) -> m_class=1.
  - Votes 6'b000011 -> m_class=0.
- Backpressure: hold m_ready=0 for 10 cycles after m_valid.
  - Outputs stay stable and s_ready stays 0.
  - A s_valid pulse during this window is not accepted.
  - Release m_ready: IDLE the next cycle, then accept the next sample.
- Reset mid-EVAL at k=2: state goes to IDLE, s_ready=1, m_valid never asserts for the aborted sample.
  - The next sample produces a correct, independent result.
